// File: rtl/modadd_ctrl.sv
// modadd_ctrl: modular add/subtract sequencer driving an external adder.
// Computes (a+b) mod m or (a-b) mod m for operands a,b < m using two
// adder passes that always both run, so latency is data-independent.
//
// Ports:
//   clk, resetn            - clock (rising edge), async active-low reset
//   start, op_sub          - request pulse (taken only in IDLE), 1 = subtract
//   in_a, in_b, in_m       - operands and modulus, captured on start
//   result, done, busy     - registered result, one-cycle done, busy flag
//   add_start/add_subtract - request and operation for the external adder
//   add_in_a, add_in_b     - adder operands (stable while its request runs)
//   add_result, add_done   - adder sum (bit WIDTH = carry/borrow) and done
module modadd_ctrl #(
  parameter int WIDTH = 384
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_in_a,
  output logic [WIDTH-1:0] add_in_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
);

  typedef enum logic [2:0] {
    IDLE,
    P1_ISSUE,
    P1_WAIT,
    P2_ISSUE,
    P2_WAIT,
    FINISH
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic             op_q;
  logic [WIDTH:0]   s_q;
  logic [WIDTH-1:0] result_q;
  logic             use_d;

  // Add: first pass may have carried out (s >= 2^WIDTH), in which case the
  // reduced value is always s-m; otherwise take s-m only if it did not borrow.
  // Subtract: a borrow on the first pass means a<b, so correct by adding m.
  assign use_d = op_q ? s_q[WIDTH] : (s_q[WIDTH] | ~add_result[WIDTH]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = P1_ISSUE;
      P1_ISSUE: state_nxt = P1_WAIT;
      P1_WAIT:  if (add_done) state_nxt = P2_ISSUE;
      P2_ISSUE: state_nxt = P2_WAIT;
      P2_WAIT:  if (add_done) state_nxt = FINISH;
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Adder operands are decoded from the registered state so they hold
  // steady across the whole issue/wait pair of each pass.
  always_comb begin
    add_start    = 1'b0;
    add_subtract = 1'b0;
    add_in_a     = '0;
    add_in_b     = '0;
    case (state)
      P1_ISSUE, P1_WAIT: begin
        add_start    = (state == P1_ISSUE);
        add_subtract = op_q;
        add_in_a     = a_q;
        add_in_b     = b_q;
      end
      P2_ISSUE, P2_WAIT: begin
        add_start    = (state == P2_ISSUE);
        add_subtract = ~op_q;
        add_in_a     = s_q[WIDTH-1:0];
        add_in_b     = m_q;
      end
      default: ;
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = (state == FINISH);
  assign result = result_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      op_q     <= 1'b0;
      s_q      <= '0;
      result_q <= '0;
    end else begin
      if (state == IDLE && start) begin
        a_q  <= in_a;
        b_q  <= in_b;
        m_q  <= in_m;
        op_q <= op_sub;
      end
      if (state == P1_WAIT && add_done) s_q <= add_result;
      if (state == P2_WAIT && add_done)
        result_q <= use_d ? add_result[WIDTH-1:0] : s_q[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_modadd_ctrl.sv
// Directed bench for modadd_ctrl with a behavioural adder of latency 3
// (add_done rises 3 cycles after add_start rises).
module tb_modadd_ctrl;
  localparam int W = 384;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          op_sub;
  logic [W-1:0]  in_a, in_b, in_m;
  logic [W-1:0]  result;
  logic          done, busy;
  logic          add_start, add_subtract;
  logic [W-1:0]  add_in_a, add_in_b;
  logic [W:0]    add_result;
  logic          add_done;

  int total = 0;
  int bad   = 0;
  int n_add_start = 0;
  int n_done = 0;

  logic [2:0] pipe = '0;
  logic [W:0] sum  = '0;
  logic       spur = 1'b0;

  localparam logic [W-1:0] P384 =
    384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;

  modadd_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op_sub(op_sub),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .result(result), .done(done), .busy(busy),
    .add_start(add_start), .add_subtract(add_subtract),
    .add_in_a(add_in_a), .add_in_b(add_in_b),
    .add_result(add_result), .add_done(add_done)
  );

  always #5 clk = ~clk;

  // Behavioural adder: W+1 bit result, bit W is carry (add) or borrow (sub).
  always @(posedge clk) begin
    pipe <= {pipe[1:0], add_start};
    if (add_start)
      sum <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                          : ({1'b0, add_in_a} + {1'b0, add_in_b});
  end
  assign add_result = sum;
  assign add_done   = pipe[2] | spur;

  always @(negedge clk) begin
    if (add_start) n_add_start++;
    if (done)      n_done++;
  end

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_result"}, {1'b0, result}, '0);
    chk({tag, "_done"}, {{W{1'b0}}, done}, '0);
    chk({tag, "_busy"}, {{W{1'b0}}, busy}, '0);
    chk({tag, "_add_start"}, {{W{1'b0}}, add_start}, '0);
    chk({tag, "_add_sub"}, {{W{1'b0}}, add_subtract}, '0);
    chk({tag, "_add_in_a"}, {1'b0, add_in_a}, '0);
    chk({tag, "_add_in_b"}, {1'b0, add_in_b}, '0);
  endtask

  // Called at #1 after a rising edge with the FSM in IDLE. The start edge
  // is the next rising edge; done is expected visible after 8 further edges,
  // i.e. it occupies the 9th clock period after the start edge.
  // intr > 0 pulses a foreign start (with junk operands) at that cycle.
  task automatic do_op(input string tag, input logic op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] m,
                       input logic [W-1:0] exp, input int intr);
    int cyc;
    int sa0;
    int dn0;
    in_a = a; in_b = b; in_m = m; op_sub = op; start = 1'b1;
    sa0 = n_add_start; dn0 = n_done;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_p1_add_start"}, {{W{1'b0}}, add_start}, 1);
    chk({tag, "_p1_in_a"}, {1'b0, add_in_a}, {1'b0, a});
    chk({tag, "_p1_in_b"}, {1'b0, add_in_b}, {1'b0, b});
    chk({tag, "_p1_sub"}, {{W{1'b0}}, add_subtract}, {{W{1'b0}}, op});
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (intr != 0 && cyc == intr) begin
        in_a = 1; in_b = 2; in_m = 5; op_sub = ~op; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, "_latency"}, cyc, 8);
    chk({tag, "_result"}, {1'b0, result}, {1'b0, exp});
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, {{W{1'b0}}, done}, 0);
    chk({tag, "_idle"}, {{W{1'b0}}, busy}, 0);
    chk({tag, "_hold"}, {1'b0, result}, {1'b0, exp});
    chk({tag, "_passes"}, n_add_start - sa0, 2);
    chk({tag, "_done_cnt"}, n_done - dn0, 1);
  endtask

  initial begin
    int cyc;
    int sa0;
    int dn0;
    resetn = 1'b0; start = 1'b0; op_sub = 1'b0;
    in_a = '0; in_b = '0; in_m = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Main function
    do_op("add_7_9",  1'b0, 7, 9, 13, 3, 0);
    do_op("sub_3_9",  1'b1, 3, 9, 13, 7, 0);
    do_op("sub_9_3",  1'b1, 9, 3, 13, 6, 0);
    do_op("p384_max", 1'b0, P384 - 1, P384 - 1, P384, P384 - 2, 0);
    do_op("p384_zero", 1'b0, 0, 0, P384, 0, 0);
    do_op("sub_eq",   1'b1, 12, 12, 13, 0, 0);

    // Spurious add_done in IDLE
    sa0 = n_add_start;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(posedge clk); #1;
    chk("spur_idle", {{W{1'b0}}, busy}, 0);
    chk("spur_no_issue", n_add_start - sa0, 0);
    chk("spur_result", {1'b0, result}, 0);

    // Start pulse while in P1_WAIT is ignored
    do_op("busy_start", 1'b0, 7, 9, 13, 3, 1);

    // Start held during FINISH is ignored, accepted in the following IDLE
    in_a = 7; in_b = 9; in_m = 13; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("fin_first", {1'b0, result}, 3);
    in_a = 1; in_b = 2; start = 1'b1;
    @(posedge clk); #1;
    chk("fin_ignored", {{W{1'b0}}, busy}, 0);
    in_a = 10; in_b = 11;
    @(posedge clk); #1;
    start = 1'b0;
    chk("fin_accept", {{W{1'b0}}, busy}, 1);
    chk("fin_accept_a", {1'b0, add_in_a}, 10);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("fin_second_lat", cyc, 8);
    chk("fin_second", {1'b0, result}, 8);
    @(posedge clk); #1;

    // Reset during P2_WAIT, released before the pending add_done arrives
    in_a = 5; in_b = 6; in_m = 13; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("rst_mid_busy_pre", {{W{1'b0}}, busy}, 1);
    resetn = 1'b0;
    #1;
    chk_zero_outputs("rst_mid");
    #1;
    resetn = 1'b1;
    sa0 = n_add_start; dn0 = n_done;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_late_idle", {{W{1'b0}}, busy}, 0);
    chk("rst_no_done", n_done - dn0, 0);
    chk("rst_no_issue", n_add_start - sa0, 0);
    chk("rst_result", {1'b0, result}, 0);
    do_op("after_rst", 1'b0, 5, 6, 13, 11, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
